// File: rtl/apb2_pkg.sv
// Shared definitions for the APB2 master arbiter slice.
//   APB_ADDR_BITS / APB_DATA_BITS : default APB2 bus widths of the tester
//   ST_IDLE / ST_SETUP / ST_ACCESS : bus FSM state encoding
//   idx_bits()                     : index width for an N-entry select
package apb2_pkg;

  localparam int APB_ADDR_BITS = 20;
  localparam int APB_DATA_BITS = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETUP  = 2'd1;
  localparam state_t ST_ACCESS = 2'd2;

  // Width of a requester index; at least one bit so N=1 still elaborates.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb2_master_arbiter_rr_arbiter.sv
// Purely combinational round-robin arbiter.
//   req         : per-requester request
//   mask        : requesters excluded from this arbitration point
//   last_grant  : most recently served requester; search starts one above it
//   grant_valid : some unmasked request is pending
//   grant_idx   : winning requester index (valid only with grant_valid)
module rr_arbiter
  import apb2_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]             req,
  input  logic [N-1:0]             mask,
  input  logic [idx_bits(N)-1:0]   last_grant,
  output logic                     grant_valid,
  output logic [idx_bits(N)-1:0]   grant_idx
);

  localparam int IDX_W = idx_bits(N);

  logic [N-1:0] elig;
  int           cand;

  assign elig = req & ~mask;

  // Walk last_grant+1 .. last_grant+N (mod N); first eligible hit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(last_grant) + i) % N;
      if (!grant_valid && elig[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/apb2_master_arbiter.sv
// Shares one APB2 peripheral bus between REQUESTERS independent command
// sources. A round-robin arbiter picks a pending request, the FSM runs the
// SETUP and ACCESS phases, read data is captured at the end of ACCESS and
// the owner gets a one-cycle done pulse.
//   clk, rst                : clock, synchronous active-high reset
//   req/req_write           : per-requester request level and direction
//   req_addr/req_wdata      : flattened per-requester address / write data
//   done                    : one-hot completion pulse (cycle after ACCESS)
//   rdata                   : data of the last completed read
//   busy                    : bus in SETUP or ACCESS
//   PADDR..PWDATA, PRDATA   : registered APB2 master interface
module apb2_master_arbiter
  import apb2_pkg::*;
#(
  parameter int REQUESTERS = 2,
  parameter int ADDR_BITS  = APB_ADDR_BITS,
  parameter int DATA_BITS  = APB_DATA_BITS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [REQUESTERS-1:0]           req,
  input  logic [REQUESTERS*ADDR_BITS-1:0] req_addr,
  input  logic [REQUESTERS-1:0]           req_write,
  input  logic [REQUESTERS*DATA_BITS-1:0] req_wdata,
  output logic [REQUESTERS-1:0]           done,
  output logic [DATA_BITS-1:0]            rdata,
  output logic                            busy,
  output logic [ADDR_BITS-1:0]            PADDR,
  output logic                            PSEL,
  output logic                            PENABLE,
  output logic                            PWRITE,
  output logic [DATA_BITS-1:0]            PWDATA,
  input  logic [DATA_BITS-1:0]            PRDATA
);

  localparam int IDX_W = idx_bits(REQUESTERS);

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        owner, last_grant, arb_last;
  logic [REQUESTERS-1:0]   mask;
  logic                    grant_valid;
  logic [IDX_W-1:0]        grant_idx;

  logic [ADDR_BITS-1:0]    addr_arr  [REQUESTERS];
  logic [DATA_BITS-1:0]    wdata_arr [REQUESTERS];

  logic                    load;
  logic                    capture;
  logic                    psel_nxt, penable_nxt;
  logic [REQUESTERS-1:0]   done_nxt;

  // Unflatten the requester buses so the winner can be selected by index.
  for (genvar g = 0; g < REQUESTERS; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_BITS +: ADDR_BITS];
    assign wdata_arr[g] = req_wdata[g*DATA_BITS +: DATA_BITS];
  end

  // In ACCESS the owner's req is still high for the running transfer, so it
  // is masked, and the search already starts after the owner (which becomes
  // last_grant at this same edge).
  always_comb begin
    mask     = '0;
    arb_last = last_grant;
    if (state == ST_ACCESS) begin
      mask[owner] = 1'b1;
      arb_last    = owner;
    end
  end

  rr_arbiter #(
    .N (REQUESTERS)
  ) u_arb (
    .req         (req),
    .mask        (mask),
    .last_grant  (arb_last),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:   state_nxt = grant_valid ? ST_SETUP : ST_IDLE;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = grant_valid ? ST_SETUP : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values for the registered APB and handshake outputs.
  always_comb begin
    load        = 1'b0;
    capture     = 1'b0;
    done_nxt    = '0;
    psel_nxt    = (state_nxt != ST_IDLE);
    penable_nxt = (state_nxt == ST_ACCESS);
    case (state)
      ST_IDLE: load = grant_valid;
      ST_ACCESS: begin
        load            = grant_valid;
        capture         = !PWRITE;
        done_nxt[owner] = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs and per-transfer context.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= '0;
      last_grant <= IDX_W'(REQUESTERS - 1);
      PADDR      <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PWDATA     <= '0;
      done       <= '0;
      rdata      <= '0;
    end else begin
      PSEL    <= psel_nxt;
      PENABLE <= penable_nxt;
      done    <= done_nxt;
      if (state == ST_ACCESS) last_grant <= owner;
      if (capture) rdata <= PRDATA;
      if (load) begin
        owner  <= grant_idx;
        PADDR  <= addr_arr[grant_idx];
        PWRITE <= req_write[grant_idx];
        PWDATA <= wdata_arr[grant_idx];
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: doc/apb2_master_arbiter.md
Name: apb2_master_arbiter

Overview:
Shares the tester's single APB2 peripheral bus (20-bit address, 8-bit data) between several independent command requesters, for example the host SPI control port and an on-FPGA test sequencer. A round-robin arbiter picks one pending request. An FSM then drives the APB2 SETUP and ACCESS phases into the peripheral slave mux. Read data is captured and handed back to the owning requester with a one-cycle done pulse.

Parameters:
REQUESTERS, 2, number of requester ports (2..8)
ADDR_BITS, 20, APB2 address width
DATA_BITS, 8, APB2 data width

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
req  input  REQUESTERS  per-requester transfer request, level
req_addr  input  REQUESTERS*ADDR_BITS  flattened addresses; requester i at [i*ADDR_BITS+:ADDR_BITS]
req_write  input  REQUESTERS  1 = write, 0 = read
req_wdata  input  REQUESTERS*DATA_BITS  flattened write data
done  output  REQUESTERS  one-cycle completion pulse, one-hot
rdata  output  DATA_BITS  read data of last completed read
busy  output  1  bus transfer in progress (SETUP or ACCESS)
PADDR  output  ADDR_BITS  APB2 address
PSEL  output  1  APB2 select
PENABLE  output  1  APB2 enable
PWRITE  output  1  APB2 direction
PWDATA  output  DATA_BITS  APB2 write data
PRDATA  input  DATA_BITS  APB2 read data from slave mux

Behaviour:
- Reset values:
  - all outputs 0 (done, rdata, busy, PADDR, PSEL, PENABLE, PWRITE, PWDATA).
  - state = IDLE; owner = 0; last_grant = REQUESTERS-1, so requester 0 wins first.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs are registered.
- IDLE:
  - If any eligible req is high, arbitrate.
  - Latch the winner's addr, write and wdata onto PADDR, PWRITE and PWDATA.
  - Set PSEL=1, PENABLE=0 and go to SETUP.
  - Otherwise hold PSEL=0, PENABLE=0.
- SETUP: exactly one cycle; set PENABLE=1 and go to ACCESS.
- ACCESS: exactly one cycle (APB2 has no PREADY).
  - On exit, assert done[owner] for the next cycle.
  - If PWRITE=0, capture PRDATA into rdata at this edge. The slave registers PRDATA at the end of SETUP, so it is valid throughout ACCESS.
  - Update last_grant = owner.
  - If another eligible req is pending, go straight to SETUP with the new winner: PSEL stays 1, PENABLE=0, new PADDR/PWRITE/PWDATA.
  - Else go to IDLE with PSEL=0, PENABLE=0.
- Latency:
  - Granted from IDLE: SETUP one cycle after req is seen, done pulse 3 cycles after req is sampled.
  - Back-to-back transfers: one every 2 cycles.
- Arbitration:
  - Round-robin; priority order is last_grant+1, last_grant+2, … wrapping modulo REQUESTERS.
  - In ACCESS, the current owner is masked, since its req is still high.
  - The owner becomes eligible again from the done cycle onward. A req still high in the done cycle is a new transfer.
- Requester protocol:
  - Hold req, addr, write and wdata stable until done.
  - Drop req in the done cycle unless another transfer is wanted.
  - Deasserting req after grant does not abort the transfer; it completes and done still pulses.
- rdata:
  - Holds until the next completed read.
  - Write transfers leave rdata unchanged.
- busy = 1 in SETUP and ACCESS.
- Simultaneous requests: only one grant per arbitration point; losers wait with no data loss.
- Reset mid-transfer: rst wins in any state.
  - PSEL and PENABLE drop the next cycle and no done is issued.
  - The slave sees an aborted transfer.

Decomposition:
- Shared package apb2_pkg:
  - APB_ADDR_BITS=20, APB_DATA_BITS=8;
  - state encoding localparams ST_IDLE, ST_SETUP, ST_ACCESS.
- One sub-module, rr_arbiter:
  - parameter N;
  - inputs req[N], mask[N], last_grant;
  - outputs grant_valid and grant_idx;
  - purely combinational.
- The FSM, capture registers and the flattened-bus slicing stay in apb2_master_arbiter.

Test Plan:
- Single write: req[0]=1, addr=0x00000, write=1, wdata=0x02 -> SETUP cycle with PSEL=1 PENABLE=0, then ACCESS with PENABLE=1 and PADDR=0x00000 PWDATA=0x02; done[0] one cycle later; rdata unchanged.
- Single read: req[1], addr=0x00000, slave model returns 0x02 -> rdata=0x02 when done[1] asserts; PWRITE=0 throughout.
- Contention: req=2'b11 asserted together from reset -> requester 0 served first, then 1 back-to-back; PSEL stays high 4 cycles; done[0] then done[1] two cycles apart.
- Fairness: req[0] and req[1] held high continuously with 4 transfers each -> grants alternate 0,1,0,1; no requester served twice in a row.
- Reset mid-transfer: assert rst during ACCESS -> next cycle PSEL=0, PENABLE=0, busy=0, no done; after release req[0] served normally first.
- Late drop: req[1] deasserted in the SETUP cycle -> transfer completes, done[1] pulses, no second transfer issued.
